// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: state encoding, opcode map
// and AU function codes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StIo     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    localparam logic [3:0] OpMova       = 4'd0;
    localparam logic [3:0] OpMovb       = 4'd1;
    localparam logic [3:0] OpMovc       = 4'd2;
    localparam logic [3:0] OpMovd       = 4'd3;
    localparam logic [3:0] OpAdd        = 4'd4;
    localparam logic [3:0] OpSub        = 4'd5;
    localparam logic [3:0] OpJmp        = 4'd6;
    localparam logic [3:0] OpJg         = 4'd7;
    localparam logic [3:0] OpIn         = 4'd8;
    localparam logic [3:0] OpOut        = 4'd9;
    localparam logic [3:0] OpMovi       = 4'd10;
    localparam logic [3:0] OpHalt       = 4'd11;
    localparam logic [3:0] OpIllegalMin = 4'd12;

    localparam logic [3:0] AcNone = 4'b0000;
    localparam logic [3:0] AcMova = 4'b0100;
    localparam logic [3:0] AcAdd  = 4'b1000;
    localparam logic [3:0] AcSub  = 4'b1001;

    // States that wait on a ram_rdy / io_rdy handshake and are subject to timeout.
    function automatic logic is_handshake_state(state_e s);
        return (s == StFetch) || (s == StMem) || (s == StIo);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Handshake wait counter: counts low-handshake cycles and flags the cycle in
// which the count reaches TO_MAX (TO_MAX must be at least 1).
module wait_timer #(
    parameter int unsigned TO_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned W = $clog2(TO_MAX + 1);
    localparam logic [W-1:0] Last = W'(TO_MAX - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // This cycle would be the TO_MAX-th consecutive cycle without a handshake.
    assign expire = en && (cnt_q == Last);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expire) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction controller: fetch/decode/execute sequencing with RAM/IO
// handshakes, handshake timeout, sticky fault flags and a retired-instruction count.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned OPW    = 4,
    parameter int unsigned TO_MAX = 15,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPW-1:0]   op,
    input  logic             gf,
    input  logic             ram_rdy,
    input  logic             io_rdy,
    input  logic             resume,
    output logic             ld_pc,
    output logic             in_pc,
    output logic             ld_ir,
    output logic             ram_re,
    output logic             ram_we,
    output logic             s1,
    output logic             s2,
    output logic             reg_we,
    output logic             au_en,
    output logic             g_en,
    output logic             in_en,
    output logic             out_en,
    output logic             s0,
    output logic [3:0]       ac,
    output logic             halted,
    output logic             illegal,
    output logic             timeout,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic             hs;
    logic             tmr_en;
    logic             tmr_clr;
    logic             expire;

    function automatic state_e decode_target(logic [OPW-1:0] v);
        state_e tgt;
        tgt = StExec;
        if (v >= OPW'(OpIllegalMin)) begin
            tgt = StHalt;
        end else begin
            case (v)
                OPW'(OpHalt):                tgt = StHalt;
                OPW'(OpMovb), OPW'(OpMovc):  tgt = StMem;
                OPW'(OpIn), OPW'(OpOut):     tgt = StIo;
                default:                     tgt = StExec;
            endcase
        end
        return tgt;
    endfunction

    assign hs      = (state_q == StIo) ? io_rdy : ram_rdy;
    assign tmr_en  = is_handshake_state(state_q) && !hs;
    assign tmr_clr = (state_d != state_q);

    wait_timer #(
        .TO_MAX (TO_MAX)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (expire)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        retire    = 1'b0;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch, StMem, StIo: begin
                // Completion has priority over an expiring wait count.
                if (hs) begin
                    state_d = (state_q == StFetch) ? StDecode : StFetch;
                    retire  = (state_q != StFetch);
                end else if (expire) begin
                    state_d   = StHalt;
                    timeout_d = 1'b1;
                end
            end
            StDecode: begin
                op_d      = op;
                state_d   = decode_target(op);
                illegal_d = illegal_q | (op >= OPW'(OpIllegalMin));
            end
            StExec: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StHalt: begin
                if (resume) begin
                    state_d   = StFetch;
                    illegal_d = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        ld_pc  = 1'b0;
        in_pc  = 1'b0;
        ld_ir  = 1'b0;
        ram_re = 1'b0;
        ram_we = 1'b0;
        s1     = 1'b0;
        s2     = 1'b0;
        reg_we = 1'b0;
        au_en  = 1'b0;
        g_en   = 1'b0;
        in_en  = 1'b0;
        out_en = 1'b0;
        s0     = 1'b1;
        ac     = AcNone;
        case (state_q)
            StFetch: begin
                ram_re = 1'b1;
                ld_ir  = ram_rdy;
                in_pc  = ram_rdy;
            end
            StExec: begin
                case (op_q)
                    OPW'(OpMova): begin
                        reg_we = 1'b1;
                        au_en  = 1'b1;
                        ac     = AcMova;
                    end
                    OPW'(OpMovd): begin
                        reg_we = 1'b1;
                        s0     = 1'b0;
                    end
                    OPW'(OpAdd): begin
                        reg_we = 1'b1;
                        au_en  = 1'b1;
                        ac     = AcAdd;
                    end
                    OPW'(OpSub): begin
                        reg_we = 1'b1;
                        au_en  = 1'b1;
                        g_en   = 1'b1;
                        ac     = AcSub;
                    end
                    OPW'(OpMovi): reg_we = 1'b1;
                    OPW'(OpJmp):  ld_pc  = 1'b1;
                    OPW'(OpJg):   ld_pc  = gf;
                    default: ;
                endcase
            end
            StMem: begin
                if (op_q == OPW'(OpMovb)) begin
                    s2     = 1'b1;
                    ram_we = 1'b1;
                end else begin
                    s1     = 1'b1;
                    ram_re = 1'b1;
                    reg_we = ram_rdy;
                end
            end
            StIo: begin
                if (op_q == OPW'(OpIn)) begin
                    in_en  = 1'b1;
                    reg_we = io_rdy;
                end else begin
                    au_en  = 1'b1;
                    out_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign halted  = (state_q == StHalt);
    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, hand-written corner sequences,
// then randomized traffic against an instruction-level reference model.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int unsigned OPW    = 4;
    localparam int unsigned TO_MAX = 15;
    localparam int unsigned CNT_W  = 8;
    localparam int          NV     = 26;
    localparam int          NRAND  = 4000;

    // Control vector bit positions: {ld_pc,in_pc,ld_ir,ram_re,ram_we,s1,s2,reg_we,
    // au_en,g_en,in_en,out_en,s0,ac[3:0]}
    localparam logic [16:0] K_LDPC = 17'h1_0000;
    localparam logic [16:0] K_INPC = 17'h0_8000;
    localparam logic [16:0] K_LDIR = 17'h0_4000;
    localparam logic [16:0] K_RE   = 17'h0_2000;
    localparam logic [16:0] K_WE   = 17'h0_1000;
    localparam logic [16:0] K_S1   = 17'h0_0800;
    localparam logic [16:0] K_S2   = 17'h0_0400;
    localparam logic [16:0] K_RWE  = 17'h0_0200;
    localparam logic [16:0] K_AU   = 17'h0_0100;
    localparam logic [16:0] K_GEN  = 17'h0_0080;
    localparam logic [16:0] K_INE  = 17'h0_0040;
    localparam logic [16:0] K_OUTE = 17'h0_0020;
    localparam logic [16:0] K_S0   = 17'h0_0010;
    localparam logic [16:0] K_FH   = K_S0 | K_RE | K_LDIR | K_INPC;

    logic             clk;
    logic             rst_n;
    logic [OPW-1:0]   op;
    logic             gf, ram_rdy, io_rdy, resume;
    logic             ld_pc, in_pc, ld_ir, ram_re, ram_we, s1, s2, reg_we;
    logic             au_en, g_en, in_en, out_en, s0;
    logic [3:0]       ac;
    logic             halted, illegal, timeout;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;
    logic [16:0]      ctl_act;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] op;
        logic       gf;
        logic       rr;
        logic       ir;
        state_e     st;
        logic [16:0] ctl;
        logic [7:0] ret;
    } vec_t;
    vec_t tbl[NV];

    // Reference model state
    state_e     m_st;
    logic [3:0] m_op;
    int         m_wait;
    logic       m_ill, m_to;
    logic [7:0] m_ret;

    multicycle_ctrl #(
        .OPW    (OPW),
        .TO_MAX (TO_MAX),
        .CNT_W  (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .op      (op),
        .gf      (gf),
        .ram_rdy (ram_rdy),
        .io_rdy  (io_rdy),
        .resume  (resume),
        .ld_pc   (ld_pc),
        .in_pc   (in_pc),
        .ld_ir   (ld_ir),
        .ram_re  (ram_re),
        .ram_we  (ram_we),
        .s1      (s1),
        .s2      (s2),
        .reg_we  (reg_we),
        .au_en   (au_en),
        .g_en    (g_en),
        .in_en   (in_en),
        .out_en  (out_en),
        .s0      (s0),
        .ac      (ac),
        .halted  (halted),
        .illegal (illegal),
        .timeout (timeout),
        .state   (state),
        .retired (retired)
    );

    assign ctl_act = {ld_pc, in_pc, ld_ir, ram_re, ram_we, s1, s2, reg_we,
                      au_en, g_en, in_en, out_en, s0, ac};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] stat_act();
        return 32'({state, halted, illegal, timeout, retired});
    endfunction

    function automatic logic [31:0] stat_exp(state_e s, logic h, logic i, logic t,
                                             logic [7:0] r);
        return 32'({s, h, i, t, r});
    endfunction

    function automatic logic [31:0] sc(state_e s, logic [16:0] c);
        return 32'({s, c});
    endfunction

    task automatic apply(input logic [3:0] o, input logic g, input logic rr,
                         input logic ir, input logic rs);
        op = o; gf = g; ram_rdy = rr; io_rdy = ir; resume = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] exec_ctl(logic [3:0] o, logic g);
        case (o)
            OpMova:  return K_S0 | K_RWE | K_AU | 17'h4;
            OpMovd:  return K_RWE;
            OpAdd:   return K_S0 | K_RWE | K_AU | 17'h8;
            OpSub:   return K_S0 | K_RWE | K_AU | K_GEN | 17'h9;
            OpMovi:  return K_S0 | K_RWE;
            OpJmp:   return K_S0 | K_LDPC;
            OpJg:    return g ? (K_S0 | K_LDPC) : K_S0;
            default: return K_S0;
        endcase
    endfunction

    task automatic model_reset();
        m_st = StIdle; m_op = '0; m_wait = 0; m_ill = 1'b0; m_to = 1'b0; m_ret = '0;
    endtask

    function automatic logic [16:0] model_ctl();
        logic [16:0] c;
        c = K_S0;
        case (m_st)
            StFetch: c = ram_rdy ? K_FH : (K_S0 | K_RE);
            StExec:  c = exec_ctl(m_op, gf);
            StMem:   c = (m_op == OpMovb) ? (K_S0 | K_S2 | K_WE)
                                          : (K_S0 | K_S1 | K_RE | (ram_rdy ? K_RWE : 17'h0));
            StIo:    c = (m_op == OpIn) ? (K_S0 | K_INE | (io_rdy ? K_RWE : 17'h0))
                                        : (K_S0 | K_AU | K_OUTE);
            default: c = K_S0;
        endcase
        return c;
    endfunction

    task automatic model_update();
        state_e nxt;
        logic   done;
        nxt = m_st;
        case (m_st)
            StIdle: nxt = StFetch;
            StDecode: begin
                m_op = op;
                if (op == OpHalt) nxt = StHalt;
                else if (op >= OpIllegalMin) begin nxt = StHalt; m_ill = 1'b1; end
                else if (op == OpMovb || op == OpMovc) nxt = StMem;
                else if (op == OpIn || op == OpOut) nxt = StIo;
                else nxt = StExec;
            end
            StExec: begin nxt = StFetch; m_ret = m_ret + 8'd1; end
            StHalt: if (resume) begin nxt = StFetch; m_ill = 1'b0; m_to = 1'b0; end
            default: begin
                done = (m_st == StIo) ? io_rdy : ram_rdy;
                if (done) begin
                    nxt = (m_st == StFetch) ? StDecode : StFetch;
                    if (m_st != StFetch) m_ret = m_ret + 8'd1;
                end else if (m_wait + 1 == int'(TO_MAX)) begin
                    nxt = StHalt; m_to = 1'b1;
                end else begin
                    m_wait++;
                end
            end
        endcase
        if (nxt != m_st) m_wait = 0;
        m_st = nxt;
    endtask

    initial begin
        vec_t mv[3];
        int   stall;
        logic rr_r, ir_r;

        tbl[0]  = '{OpAdd,  1'b0, 1'b1, 1'b0, StIdle,   K_S0, 8'd0};
        tbl[1]  = '{OpAdd,  1'b0, 1'b1, 1'b0, StFetch,  K_FH, 8'd0};
        tbl[2]  = '{OpAdd,  1'b0, 1'b1, 1'b0, StDecode, K_S0, 8'd0};
        tbl[3]  = '{OpAdd,  1'b0, 1'b1, 1'b0, StExec,   K_S0 | K_RWE | K_AU | 17'h8, 8'd0};
        tbl[4]  = '{OpJg,   1'b0, 1'b1, 1'b0, StFetch,  K_FH, 8'd1};
        tbl[5]  = '{OpJg,   1'b0, 1'b1, 1'b0, StDecode, K_S0, 8'd1};
        tbl[6]  = '{OpJg,   1'b0, 1'b1, 1'b0, StExec,   K_S0, 8'd1};
        tbl[7]  = '{OpJg,   1'b1, 1'b1, 1'b0, StFetch,  K_FH, 8'd2};
        tbl[8]  = '{OpJg,   1'b1, 1'b1, 1'b0, StDecode, K_S0, 8'd2};
        tbl[9]  = '{OpJg,   1'b1, 1'b1, 1'b0, StExec,   K_S0 | K_LDPC, 8'd2};
        tbl[10] = '{OpMovc, 1'b0, 1'b1, 1'b0, StFetch,  K_FH, 8'd3};
        tbl[11] = '{OpMovc, 1'b0, 1'b1, 1'b0, StDecode, K_S0, 8'd3};
        tbl[12] = '{OpMovc, 1'b0, 1'b0, 1'b1, StMem,    K_S0 | K_S1 | K_RE, 8'd3};
        tbl[13] = '{OpMovc, 1'b0, 1'b0, 1'b1, StMem,    K_S0 | K_S1 | K_RE, 8'd3};
        tbl[14] = '{OpMovc, 1'b0, 1'b0, 1'b1, StMem,    K_S0 | K_S1 | K_RE, 8'd3};
        tbl[15] = '{OpMovc, 1'b0, 1'b1, 1'b0, StMem,    K_S0 | K_S1 | K_RE | K_RWE, 8'd3};
        tbl[16] = '{OpSub,  1'b0, 1'b1, 1'b0, StFetch,  K_FH, 8'd4};
        tbl[17] = '{OpSub,  1'b0, 1'b1, 1'b0, StDecode, K_S0, 8'd4};
        tbl[18] = '{OpSub,  1'b0, 1'b1, 1'b0, StExec,   K_S0 | K_RWE | K_AU | K_GEN | 17'h9, 8'd4};
        tbl[19] = '{OpMovd, 1'b0, 1'b1, 1'b0, StFetch,  K_FH, 8'd5};
        tbl[20] = '{OpMovd, 1'b0, 1'b1, 1'b0, StDecode, K_S0, 8'd5};
        tbl[21] = '{OpMovd, 1'b0, 1'b1, 1'b0, StExec,   K_RWE, 8'd5};
        tbl[22] = '{OpOut,  1'b0, 1'b1, 1'b0, StFetch,  K_FH, 8'd6};
        tbl[23] = '{OpOut,  1'b0, 1'b1, 1'b0, StDecode, K_S0, 8'd6};
        tbl[24] = '{OpOut,  1'b0, 1'b1, 1'b0, StIo,     K_S0 | K_AU | K_OUTE, 8'd6};
        tbl[25] = '{OpOut,  1'b0, 1'b1, 1'b1, StIo,     K_S0 | K_AU | K_OUTE, 8'd6};

        // Reset values, including across clock edges while held
        rst_n = 1'b0;
        apply(OpAdd, 1'b0, 1'b1, 1'b1, 1'b1);
        #3;
        check("reset_ctl", 32'(ctl_act), 32'(K_S0));
        check("reset_stat", stat_act(), stat_exp(StIdle, 1'b0, 1'b0, 1'b0, 8'd0));
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", stat_act(), stat_exp(StIdle, 1'b0, 1'b0, 1'b0, 8'd0));
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i].op, tbl[i].gf, tbl[i].rr, tbl[i].ir, 1'b0);
            #2;
            check($sformatf("vec%0d", i), 32'({state, ctl_act, retired}),
                  32'({tbl[i].st, tbl[i].ctl, tbl[i].ret}));
            tick();
        end

        // IN with io_rdy never arriving: 15 wait cycles, then HALT with timeout
        apply(OpIn, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        for (int k = 0; k < 15; k++) begin
            apply(OpIn, 1'b0, 1'b1, 1'b0, 1'b0);
            #2;
            check($sformatf("io_wait%0d", k), sc(state_e'(state), ctl_act), sc(StIo, K_S0 | K_INE));
            tick();
        end
        #2;
        check("io_to_stat", stat_act(), stat_exp(StHalt, 1'b1, 1'b0, 1'b1, 8'd7));
        check("io_to_ctl", 32'(ctl_act), 32'(K_S0));
        apply(OpIn, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        apply(OpIn, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        check("resume_to", stat_act(), stat_exp(StFetch, 1'b0, 1'b0, 1'b0, 8'd7));

        // io_rdy in the last permitted cycle completes; resume held high is ignored
        tick();
        tick();
        for (int k = 0; k < 15; k++) begin
            apply(OpIn, 1'b0, 1'b1, (k == 14), 1'b1);
            #2;
            check($sformatf("io_late%0d", k), sc(state_e'(state), ctl_act),
                  sc(StIo, (k == 14) ? (K_S0 | K_INE | K_RWE) : (K_S0 | K_INE)));
            tick();
        end

        // FETCH with ram_rdy never arriving: no ld_ir, then timeout
        for (int k = 0; k < 15; k++) begin
            apply(OpAdd, 1'b0, 1'b0, 1'b0, 1'b1);
            #2;
            if (k == 0)
                check("io_late_done", stat_act(), stat_exp(StFetch, 1'b0, 1'b0, 1'b0, 8'd8));
            check($sformatf("fetch_wait%0d", k), 32'(ctl_act), 32'(K_S0 | K_RE));
            tick();
        end
        apply(OpAdd, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        check("fetch_to", stat_act(), stat_exp(StHalt, 1'b1, 1'b0, 1'b1, 8'd8));
        tick();
        #2;
        check("halt_stays", stat_act(), stat_exp(StHalt, 1'b1, 1'b0, 1'b1, 8'd8));
        apply(OpAdd, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        apply(OpAdd, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        check("resume_fetch_to", stat_act(), stat_exp(StFetch, 1'b0, 1'b0, 1'b0, 8'd8));

        // Illegal opcode 13, then the HALT opcode
        tick();
        apply(4'd13, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        #2;
        check("illegal", stat_act(), stat_exp(StHalt, 1'b1, 1'b1, 1'b0, 8'd8));
        apply(OpAdd, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        apply(OpAdd, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        check("illegal_clr", stat_act(), stat_exp(StFetch, 1'b0, 1'b0, 1'b0, 8'd8));
        tick();
        apply(OpHalt, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        #2;
        check("halt_op", stat_act(), stat_exp(StHalt, 1'b1, 1'b0, 1'b0, 8'd8));
        apply(OpAdd, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        apply(OpAdd, 1'b0, 1'b1, 1'b0, 1'b0);

        // Counter wrap: drive retired to all-ones, then one more ADD
        for (int n = 0; n < 247; n++) begin
            tick();
            tick();
            tick();
        end
        #2;
        check("ret_max", stat_act(), stat_exp(StFetch, 1'b0, 1'b0, 1'b0, 8'hFF));
        tick();
        tick();
        tick();
        #2;
        check("ret_wrap", stat_act(), stat_exp(StFetch, 1'b0, 1'b0, 1'b0, 8'h00));

        // Reset in the middle of a MOVB memory wait
        apply(OpMovb, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        apply(OpMovb, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("movb_mem", sc(state_e'(state), ctl_act), sc(StMem, K_S0 | K_S2 | K_WE));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_ctl", 32'(ctl_act), 32'(K_S0));
        check("async_rst_stat", stat_act(), stat_exp(StIdle, 1'b0, 1'b0, 1'b0, 8'd0));
        apply(OpMovb, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        mv[0] = '{OpMovb, 1'b0, 1'b1, 1'b0, StIdle,   K_S0, 8'd0};
        mv[1] = '{OpMovb, 1'b0, 1'b1, 1'b0, StFetch,  K_FH, 8'd0};
        mv[2] = '{OpMovb, 1'b0, 1'b1, 1'b0, StDecode, K_S0, 8'd0};
        for (int k = 0; k < 3; k++) begin
            #2;
            check($sformatf("post_rst%0d", k), 32'({state, ctl_act, retired}),
                  32'({mv[k].st, mv[k].ctl, mv[k].ret}));
            tick();
        end

        // Randomized traffic against the reference model
        rst_n = 1'b0;
        #1;
        model_reset();
        tick();
        rst_n = 1'b1;
        stall = 0;
        for (int c = 0; c < NRAND; c++) begin
            if (stall == 0 && $urandom_range(0, 39) == 0) stall = $urandom_range(8, 20);
            rr_r = (stall > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            ir_r = (stall > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (stall > 0) stall--;
            apply(($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15))
                                              : 4'($urandom_range(0, 11)),
                  1'($urandom_range(0, 1)), rr_r, ir_r, 1'($urandom_range(0, 1)));
            #2;
            check($sformatf("rnd_ctl%0d", c), 32'(ctl_act), 32'(model_ctl()));
            check($sformatf("rnd_stat%0d", c), stat_act(),
                  stat_exp(m_st, (m_st == StHalt), m_ill, m_to, m_ret));
            model_update();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter OPW, default 4: opcode width.
REQ-002 Parameter TO_MAX, default 15: maximum ready-wait cycles before timeout.
REQ-003 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-004 Port clk  in  1: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n  in  1: reset, asynchronous and active-low.
REQ-006 Port op  in  OPW: opcode from IR, captured in DECODE.
REQ-007 Port gf  in  1: status flag G, sampled in EXEC.
REQ-008 Ports ram_rdy, io_rdy  in  1 each: RAM / IO transfer-complete handshakes.
REQ-009 Port resume  in  1: leave HALT.
REQ-010 Ports ld_pc, in_pc, ld_ir, ram_re, ram_we, s1, s2, reg_we, au_en, g_en, in_en, out_en, s0  out  1 each: datapath controls, same meaning as the two-phase controller.
REQ-011 Port ac  out  4: AU function code.
REQ-012 Ports halted, illegal, timeout  out  1 each: halted = state is HALT; illegal and timeout are sticky cause flags.
REQ-013 Port state  out  3: current state encoding.
REQ-014 Port retired  out  CNT_W: count of completed instructions.

Function
REQ-015 States are IDLE, FETCH, DECODE, EXEC, MEM, IO, HALT; all outputs are Moore-decoded from state plus latched opcode, except the single handshake-completion cycles named below.
REQ-016 IDLE asserts no control and moves unconditionally to FETCH on the next clk.
REQ-017 FETCH asserts ram_re every cycle; in the cycle ram_rdy=1 it asserts ld_ir and in_pc, and the next state is DECODE.
REQ-018 DECODE latches op and asserts no control; next state: HALT opcode -> HALT; MOVB/MOVC -> MEM; IN/OUT -> IO; undefined opcode -> HALT with illegal set; otherwise -> EXEC.
REQ-019 EXEC lasts one cycle and returns to FETCH: MOVA -> reg_we, au_en, ac=0100; MOVD -> reg_we, s0=0; ADD -> reg_we, au_en, ac=1000; SUB -> reg_we, au_en, g_en, ac=1001; MOVI -> reg_we; JMP -> ld_pc; JG -> ld_pc only if gf=1.
REQ-020 s0 is 1 in every cycle except EXEC of MOVD; ac is 0000 outside the EXEC cycles listed.
REQ-021 MEM with MOVB holds s2 and ram_we; with MOVC it holds s1 and ram_re, and asserts reg_we in the ram_rdy=1 cycle; it exits to FETCH on ram_rdy=1.
REQ-022 IO with IN holds in_en and asserts reg_we in the io_rdy=1 cycle; with OUT it holds au_en and out_en; it exits to FETCH on io_rdy=1.
REQ-023 retired increments by 1 on each EXEC cycle and on each MEM/IO completion cycle, and wraps from 2^CNT_W-1 to 0; it does not increment on HALT or illegal opcodes.
REQ-024 The wait counter clears on entry to FETCH/MEM/IO and increments each cycle while the handshake is low; on reaching TO_MAX with the handshake still low, the next state is HALT, timeout=1, and no ld_ir/reg_we pulse occurs.
REQ-025 A handshake arriving in the same cycle the counter reaches TO_MAX completes normally; completion wins.
REQ-026 HALT asserts only halted; resume=1 moves to FETCH and clears illegal and timeout; resume is ignored in every other state.
REQ-027 The opcode map is MOVA 0, MOVB 1, MOVC 2, MOVD 3, ADD 4, SUB 5, JMP 6, JG 7, IN 8, OUT 9, MOVI 10, HALT 11; values 12 and above are illegal.

Reset
REQ-028 While rst_n=0: state=IDLE, all 1-bit controls 0 except s0=1, ac=0000, illegal=0, timeout=0, retired=0, and the wait counter and latched op are 0.
REQ-029 Reset asserted in any state, including mid-handshake, aborts the operation immediately, with no completion pulse.

Structure
REQ-030 The opcode constants, state encoding and ac codes live in a shared package used by the controller and its testbench.
REQ-031 One sub-module, wait_timer (clear, count enable, TO_MAX compare), is instantiated for REQ-024.

Verification
REQ-032 Release reset, hold ram_rdy=1, op=ADD -> states IDLE,FETCH,DECODE,EXEC,FETCH; EXEC shows reg_we=1, au_en=1, ac=1000; retired=1.
REQ-033 op=JG with gf=0, then op=JG with gf=1 -> ld_pc stays 0 in the first EXEC and is 1 in the second.
REQ-034 op=MOVC with ram_rdy low for 3 MEM cycles, then high -> s1 and ram_re held for 4 cycles, reg_we only in the 4th, then FETCH.
REQ-035 op=IN with io_rdy never asserted, TO_MAX=15 -> HALT after 15 IO wait cycles with timeout=1; then resume=1 -> FETCH with timeout=0.
REQ-036 op=13 -> HALT with illegal=1 and retired unchanged; retired preloaded to 0xFFFF, then one ADD -> retired=0x0000.
REQ-037 rst_n low during MEM of MOVB -> outputs take the REQ-028 values asynchronously, with no ram_we after release.
